// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the uart_ext block.
//   - parity mode encodings (2'b11 is treated as no parity)
//   - TX / RX state enums
//   - RX FIFO entry {ferr, perr, data}; data is sized for the widest frame
//     (9 bits) and narrower words are LSB-justified with zero fill.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP
  } rx_state_e;

  typedef struct packed {
    logic                     ferr;
    logic                     perr;
    logic [MAX_DATA_BITS-1:0] data;
  } rx_entry_t;

  // Parity bit present on the wire for this mode.
  function automatic logic par_en(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: baud tick prescaler.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   restart_i      : zero the counter and latch compare_i as the divisor
//   compare_i      : divisor; one tick every compare_i+1 clocks
//   tick_o         : one-cycle baud tick
// The divisor is latched on restart so a frame in flight is unaffected by
// software changing the rate mid-frame.
module uart_baud_gen (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        restart_i,
  input  logic [15:0] compare_i,
  output logic        tick_o
);

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cmp_q, cmp_d;

  always_comb begin
    cmp_d = cmp_q;
    cnt_d = cnt_q + 16'd1;
    if (restart_i) begin
      cmp_d = compare_i;
      cnt_d = '0;
    end else if (cnt_q == cmp_q) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      cmp_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      cmp_q <= cmp_d;
    end
  end

  assign tick_o = (cnt_q == cmp_q);

endmodule

// File: rtl/uart_ext.sv
// uart_ext: UART with configurable width, runtime parity / stop selection,
// oversampled receiver with false-start rejection and an FWFT RX FIFO.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   compare             : baud divisor (tick every compare+1 clocks)
//   parity_mode_i       : 00 none, 01 even, 10 odd, 11 none
//   stop2_i             : two TX stop bits
//   rx_i / tx_o         : serial pins (tx_o idles high)
//   tx_data_i/valid/ready: TX word handshake
//   rx_data/perr/ferr/valid_o, rx_pop_i : FIFO head and pop
//   rx_overflow_o, rx_ovf_clr_i         : sticky overflow flag and clear
module uart_ext
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [15:0]          compare,
  input  logic [1:0]           parity_mode_i,
  input  logic                 stop2_i,
  input  logic                 rx_i,
  output logic                 tx_o,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_perr_o,
  output logic                 rx_ferr_o,
  output logic                 rx_valid_o,
  input  logic                 rx_pop_i,
  output logic                 rx_overflow_o,
  input  logic                 rx_ovf_clr_i
);

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]     BIT_LAST = 4'(DATA_BITS - 1);

  // ---------------- TX ----------------
  tx_state_e             tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0]  tx_sh_q, tx_sh_d;
  logic [3:0]            tx_bit_q, tx_bit_d;
  logic [OSW-1:0]        tx_os_q, tx_os_d;
  logic                  tx_par_q, tx_par_d;
  logic                  tx_pen_q, tx_pen_d;
  logic                  tx_stop2_q, tx_stop2_d;
  logic                  tx_q, tx_d;
  logic                  tx_restart, tx_tick;

  uart_baud_gen u_tx_baud (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .restart_i (tx_restart),
    .compare_i (compare),
    .tick_o    (tx_tick)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_sh_d    = tx_sh_q;
    tx_bit_d   = tx_bit_q;
    tx_os_d    = tx_os_q;
    tx_par_d   = tx_par_q;
    tx_pen_d   = tx_pen_q;
    tx_stop2_d = tx_stop2_q;
    tx_d       = tx_q;
    tx_restart = 1'b0;
    if (tx_state_q == TX_IDLE) begin
      if (tx_valid_i) begin
        tx_restart = 1'b1;
        tx_state_d = TX_START;
        tx_sh_d    = tx_data_i;
        tx_pen_d   = par_en(parity_mode_i);
        tx_par_d   = (^tx_data_i) ^ (parity_mode_i == PAR_ODD);
        tx_stop2_d = stop2_i;
        tx_os_d    = '0;
        tx_bit_d   = '0;
        tx_d       = 1'b0;
      end
    end else if (tx_tick) begin
      tx_os_d = tx_os_q + 1'b1;
      // Line changes only at the end of the last tick of a bit.
      if (tx_os_q == OS_LAST) begin
        tx_os_d = '0;
        case (tx_state_q)
          TX_START: begin
            tx_state_d = TX_DATA;
            tx_d       = tx_sh_q[0];
            tx_sh_d    = tx_sh_q >> 1;
          end
          TX_DATA: begin
            if (tx_bit_q == BIT_LAST) begin
              tx_bit_d = '0;
              if (tx_pen_q) begin
                tx_state_d = TX_PAR;
                tx_d       = tx_par_q;
              end else begin
                tx_state_d = TX_STOP;
                tx_d       = 1'b1;
              end
            end else begin
              tx_bit_d = tx_bit_q + 4'd1;
              tx_d     = tx_sh_q[0];
              tx_sh_d  = tx_sh_q >> 1;
            end
          end
          TX_PAR: begin
            tx_state_d = TX_STOP;
            tx_bit_d   = '0;
            tx_d       = 1'b1;
          end
          TX_STOP: begin
            if (tx_stop2_q && (tx_bit_q == 4'd0)) begin
              tx_bit_d = 4'd1;
            end else begin
              tx_state_d = TX_IDLE;
            end
            tx_d = 1'b1;
          end
          default: tx_state_d = TX_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state_q <= TX_IDLE;
      tx_sh_q    <= '0;
      tx_bit_q   <= '0;
      tx_os_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_pen_q   <= 1'b0;
      tx_stop2_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_sh_q    <= tx_sh_d;
      tx_bit_q   <= tx_bit_d;
      tx_os_q    <= tx_os_d;
      tx_par_q   <= tx_par_d;
      tx_pen_q   <= tx_pen_d;
      tx_stop2_q <= tx_stop2_d;
      tx_q       <= tx_d;
    end
  end

  assign tx_o       = tx_q;
  assign tx_ready_o = (tx_state_q == TX_IDLE);

  // ---------------- RX ----------------
  rx_state_e             rx_state_q, rx_state_d;
  logic                  rx_s1_q, rx_s2_q, rx_prev_q;
  logic [DATA_BITS-1:0]  rx_sh_q, rx_sh_d;
  logic [3:0]            rx_bit_q, rx_bit_d;
  logic [OSW-1:0]        rx_os_q, rx_os_d;
  logic                  rx_pen_q, rx_pen_d;
  logic                  rx_podd_q, rx_podd_d;
  logic                  rx_par_q, rx_par_d;
  logic                  rx_restart, rx_tick, rx_fall;
  logic                  push;
  rx_entry_t             push_entry;

  uart_baud_gen u_rx_baud (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .restart_i (rx_restart),
    .compare_i (compare),
    .tick_o    (rx_tick)
  );

  assign rx_fall = rx_prev_q & ~rx_s2_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_sh_d    = rx_sh_q;
    rx_bit_d   = rx_bit_q;
    rx_os_d    = rx_os_q;
    rx_pen_d   = rx_pen_q;
    rx_podd_d  = rx_podd_q;
    rx_par_d   = rx_par_q;
    rx_restart = 1'b0;
    push       = 1'b0;
    push_entry = '0;
    push_entry.data[DATA_BITS-1:0] = rx_sh_q;
    push_entry.perr = rx_pen_q & (rx_par_q != ((^rx_sh_q) ^ rx_podd_q));
    push_entry.ferr = ~rx_s2_q;
    if (rx_state_q == RX_IDLE) begin
      if (rx_fall) begin
        rx_restart = 1'b1;
        rx_state_d = RX_START;
        rx_os_d    = '0;
        rx_bit_d   = '0;
        rx_pen_d   = par_en(parity_mode_i);
        rx_podd_d  = (parity_mode_i == PAR_ODD);
      end
    end else if (rx_tick) begin
      rx_os_d = rx_os_q + 1'b1;
      case (rx_state_q)
        RX_START: begin
          // Half a bit in: a high line means the edge was a glitch.
          if (rx_os_q == OS_HALF) begin
            rx_os_d    = '0;
            rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_os_q == OS_LAST) begin
            rx_os_d = '0;
            rx_sh_d = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
            if (rx_bit_q == BIT_LAST) begin
              rx_state_d = rx_pen_q ? RX_PAR : RX_STOP;
            end else begin
              rx_bit_d = rx_bit_q + 4'd1;
            end
          end
        end
        RX_PAR: begin
          if (rx_os_q == OS_LAST) begin
            rx_os_d    = '0;
            rx_par_d   = rx_s2_q;
            rx_state_d = RX_STOP;
          end
        end
        RX_STOP: begin
          // Only the first stop bit is checked; idle afterwards so a
          // following start edge is caught even with one stop bit.
          if (rx_os_q == OS_LAST) begin
            push       = 1'b1;
            rx_state_d = RX_IDLE;
          end
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_state_q <= RX_IDLE;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_sh_q    <= '0;
      rx_bit_q   <= '0;
      rx_os_q    <= '0;
      rx_pen_q   <= 1'b0;
      rx_podd_q  <= 1'b0;
      rx_par_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_s1_q    <= rx_i;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_sh_q    <= rx_sh_d;
      rx_bit_q   <= rx_bit_d;
      rx_os_q    <= rx_os_d;
      rx_pen_q   <= rx_pen_d;
      rx_podd_q  <= rx_podd_d;
      rx_par_q   <= rx_par_d;
    end
  end

  // ---------------- RX FIFO (first-word fall-through) ----------------
  rx_entry_t       mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     cnt_q;
  logic            ovf_q;
  logic            pop, full, wr, ovf_set;
  rx_entry_t       head;

  assign pop     = rx_pop_i && (cnt_q != '0);
  assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot the push needs.
  assign wr      = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr)  wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
      // A new overflow wins over a simultaneous clear.
      ovf_q <= ovf_set | (ovf_q & ~rx_ovf_clr_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wptr_q] <= push_entry;
  end

  assign head          = mem_q[rptr_q];
  assign rx_valid_o    = (cnt_q != '0);
  assign rx_data_o     = rx_valid_o ? head.data[DATA_BITS-1:0] : '0;
  assign rx_perr_o     = rx_valid_o & head.perr;
  assign rx_ferr_o     = rx_valid_o & head.ferr;
  assign rx_overflow_o = ovf_q;

endmodule

// File: tb/tb_uart_ext.sv
// tb_uart_ext: directed tests for uart_ext (8 data bits, 16x, depth 8,
// compare=0 so one bit is 16 clocks).
module tb_uart_ext;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] compare = 16'd0;
  logic [1:0]  pmode = 2'b00;
  logic        stop2 = 1'b0;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;
  logic        rx_line;
  logic        tx;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        perr, ferr, rx_valid;
  logic        pop = 1'b0;
  logic        ovf;
  logic        clr = 1'b0;

  int checks = 0;
  int errors = 0;

  assign rx_line = loop_en ? tx : rx_drv;
  always #5 clk = ~clk;

  uart_ext #(.DATA_BITS(8), .OVERSAMPLE(16), .FIFO_DEPTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .compare(compare), .parity_mode_i(pmode),
    .stop2_i(stop2), .rx_i(rx_line), .tx_o(tx), .tx_data_i(tx_data),
    .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .rx_data_o(rx_data),
    .rx_perr_o(perr), .rx_ferr_o(ferr), .rx_valid_o(rx_valid),
    .rx_pop_i(pop), .rx_overflow_o(ovf), .rx_ovf_clr_i(clr)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_pop();
    pop = 1'b1;
    step(1);
    pop = 1'b0;
  endtask

  task automatic wait_rx(input int budget);
    int i;
    i = 0;
    while (!rx_valid && i < budget) begin
      step(1);
      i++;
    end
  endtask

  // Drive one 8N1 frame on rx_drv; start bit begins in the current cycle.
  task automatic drive_frame(input logic [7:0] d, input logic stopb);
    rx_drv = 1'b0;
    step(16);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      step(16);
    end
    rx_drv = stopb;
    step(16);
    rx_drv = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    checks++;
    if ({tx, tx_ready, rx_valid, rx_data, perr, ferr, ovf} !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got tx=%b rdy=%b val=%b data=%h p=%b f=%b ovf=%b", tx, tx_ready, rx_valid, rx_data, perr, ferr, ovf);
    end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_tx_8n1();
    logic [7:0] pat;
    logic       exp;
    pat = 8'hA5;
    loop_en = 1'b0; pmode = 2'b00; stop2 = 1'b0;
    tx_data = 8'hA5; tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++; $display("FAIL tx_ready_busy got %b exp 0", tx_ready);
    end
    for (int c = 1; c <= 160; c++) begin
      if (c <= 16)      exp = 1'b0;
      else if (c > 144) exp = 1'b1;
      else              exp = pat[(c - 17) / 16];
      checks++;
      if (tx !== exp) begin
        errors++; $display("FAIL tx_wave cycle %0d got %b exp %b", c, tx, exp);
      end
      if (c == 160) begin
        checks++;
        if (tx_ready !== 1'b0) begin
          errors++; $display("FAIL tx_ready_c160 got %b exp 0", tx_ready);
        end
      end
      step(1);
    end
    checks++;
    if (tx_ready !== 1'b1 || tx !== 1'b1) begin
      errors++; $display("FAIL tx_ready_c161 got rdy=%b tx=%b exp 1 1", tx_ready, tx);
    end
  endtask

  task automatic test_loopback_even_2stop();
    loop_en = 1'b1; pmode = 2'b01; stop2 = 1'b1;
    tx_data = 8'h37; tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    for (int c = 1; c <= 192; c++) begin
      if (c == 153 || c == 177) begin
        checks++;
        if (tx !== 1'b1) begin
          errors++; $display("FAIL lb_wire cycle %0d got %b exp 1", c, tx);
        end
      end
      if (c == 192) begin
        checks++;
        if (tx_ready !== 1'b0) begin
          errors++; $display("FAIL lb_ready_c192 got %b exp 0", tx_ready);
        end
      end
      step(1);
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("FAIL lb_ready_c193 got %b exp 1", tx_ready);
    end
    wait_rx(50);
    checks++;
    if ({rx_valid, rx_data, perr, ferr} !== {1'b1, 8'h37, 1'b0, 1'b0}) begin
      errors++; $display("FAIL lb_rx got val=%b data=%h p=%b f=%b exp 1 37 0 0", rx_valid, rx_data, perr, ferr);
    end
    do_pop();
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL lb_pop_empty got %b exp 0", rx_valid);
    end
    loop_en = 1'b0; pmode = 2'b00; stop2 = 1'b0;
    step(20);
  endtask

  task automatic test_ferr_glitch();
    drive_frame(8'h5A, 1'b0);
    wait_rx(20);
    checks++;
    if ({rx_valid, rx_data, perr, ferr} !== {1'b1, 8'h5A, 1'b0, 1'b1}) begin
      errors++; $display("FAIL ferr_frame got val=%b data=%h p=%b f=%b exp 1 5a 0 1", rx_valid, rx_data, perr, ferr);
    end
    do_pop();
    rx_drv = 1'b0;
    step(4);
    rx_drv = 1'b1;
    step(40);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL glitch_push got %b exp 0", rx_valid);
    end
    drive_frame(8'h81, 1'b1);
    wait_rx(20);
    checks++;
    if ({rx_valid, rx_data, perr, ferr} !== {1'b1, 8'h81, 1'b0, 1'b0}) begin
      errors++; $display("FAIL after_glitch got val=%b data=%h p=%b f=%b exp 1 81 0 0", rx_valid, rx_data, perr, ferr);
    end
    do_pop();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) begin
      drive_frame(8'(i), 1'b1);
      step(2);
    end
    checks++;
    if (ovf !== 1'b1 || rx_valid !== 1'b1) begin
      errors++; $display("FAIL ovf_set got ovf=%b val=%b exp 1 1", ovf, rx_valid);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rx_data !== 8'(i) || rx_valid !== 1'b1) begin
        errors++; $display("FAIL ovf_pop%0d got %h val=%b exp %h", i, rx_data, rx_valid, 8'(i));
      end
      do_pop();
    end
    checks++;
    if (rx_valid !== 1'b0 || ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_drained got val=%b ovf=%b exp 0 1", rx_valid, ovf);
    end
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_clr got %b exp 0", ovf);
    end
  endtask

  task automatic test_full_pop_push();
    for (int i = 0; i < 8; i++) begin
      drive_frame(8'(i), 1'b0 | 1'b1);
      step(2);
    end
    // The stop sample of a frame started now lands in relative cycle 155.
    fork
      drive_frame(8'h09, 1'b1);
      begin step(154); pop = 1'b1; step(1); pop = 1'b0; end
    join
    step(2);
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL fullpop_ovf got %b exp 0", ovf);
    end
    fork
      drive_frame(8'h0A, 1'b1);
      begin step(154); clr = 1'b1; step(1); clr = 1'b0; end
    join
    step(2);
    checks++;
    if (ovf !== 1'b1) begin
      errors++; $display("FAIL clr_vs_set got %b exp 1", ovf);
    end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (rx_data !== ((i == 8) ? 8'h09 : 8'(i))) begin
        errors++; $display("FAIL fullpop_entry%0d got %h", i, rx_data);
      end
      do_pop();
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL fullpop_empty got %b exp 0", rx_valid);
    end
    clr = 1'b1; step(1); clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    int c;
    loop_en = 1'b1;
    tx_data = 8'h3C; tx_valid = 1'b1;
    step(1);
    tx_data = 8'hC5;
    c = 1;
    while (!tx_ready && c < 300) begin
      step(1);
      c++;
    end
    checks++;
    if (c !== 161 || tx !== 1'b1) begin
      errors++; $display("FAIL b2b_ready got cycle %0d tx=%b exp 161 1", c, tx);
    end
    step(1);
    tx_valid = 1'b0;
    checks++;
    if (tx !== 1'b0 || tx_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_start got tx=%b rdy=%b exp 0 0", tx, tx_ready);
    end
    step(170);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
      errors++; $display("FAIL b2b_first got val=%b data=%h exp 1 3c", rx_valid, rx_data);
    end
    do_pop();
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hC5) begin
      errors++; $display("FAIL b2b_second got val=%b data=%h exp 1 c5", rx_valid, rx_data);
    end
    do_pop();
    loop_en = 1'b0;
    step(5);
  endtask

  task automatic test_reset_midframe();
    int c;
    drive_frame(8'h11, 1'b1);
    step(4);
    loop_en = 1'b1;
    tx_data = 8'hFF; tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    step(60);
    rst = 1'b1;
    step(1);
    checks++;
    if ({tx, tx_ready, rx_valid, rx_data, perr, ferr, ovf} !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midframe_reset got tx=%b rdy=%b val=%b data=%h p=%b f=%b ovf=%b", tx, tx_ready, rx_valid, rx_data, perr, ferr, ovf);
    end
    rst = 1'b0;
    step(3);
    tx_data = 8'hC3; tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    c = 0;
    while (!tx_ready && c < 300) begin
      step(1);
      c++;
    end
    wait_rx(50);
    checks++;
    if ({tx_ready, rx_valid, rx_data, perr, ferr} !== {1'b1, 1'b1, 8'hC3, 1'b0, 1'b0}) begin
      errors++; $display("FAIL post_reset_frame got rdy=%b val=%b data=%h p=%b f=%b exp 1 1 c3 0 0", tx_ready, rx_valid, rx_data, perr, ferr);
    end
    do_pop();
    loop_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tx_8n1();
    step(5);
    test_loopback_even_2stop();
    test_ferr_glitch();
    test_overflow();
    test_full_pop_push();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
